line_peak_extractor: RTL and testbench
======================================

Name: line_peak_extractor

Overview:
- Downstream consumer of the dual-channel ADC capture stage.
- Takes the two 12-bit pixel streams (Data1/Data2) produced while the linear optical sensor is read out, framed by the SI line-start pulse.
- Per sensor line and per channel, computes the peak pixel value, the peak pixel index and the line intensity sum.
- Presents one result set per line through a valid/ready register for the softcore/GPIO readout.

Parameters:
- NUM_PIXELS, 128, pixels per sensor line (must be a power of two, >= 2).
- DATA_W, 12, ADC sample width.
- IDX_W, 7, pixel index width = log2(NUM_PIXELS).
- SUM_W, 19, line sum width = DATA_W + IDX_W (cannot overflow).

Ports:
- clk_20M  input  1  system clock, same 20 MHz domain as the ADC capture stage.
- reset  input  1  asynchronous, active-high reset.
- line_start  input  1  one-cycle pulse (SI, synchronised to clk_20M) marking the start of a line.
- sample_valid  input  1  one-cycle strobe; data1/data2 hold a new pixel pair.
- data1  input  DATA_W  channel 1 pixel sample.
- data2  input  DATA_W  channel 2 pixel sample.
- result_ready  input  1  consumer accepts the result when high together with result_valid.
- clear_flags  input  1  synchronous clear of the overrun and short_line sticky flags.
- result_valid  output  1  result registers hold an unconsumed line result.
- peak1_value, peak2_value  output  DATA_W  maximum sample of the line.
- peak1_index, peak2_index  output  IDX_W  pixel index of that maximum.
- sum1, sum2  output  SUM_W  sum of all NUM_PIXELS samples.
- line_count  output  16  completed lines since reset; wraps 0xFFFF -> 0.
- overrun  output  1  sticky: a completed result overwrote an unconsumed one.
- short_line  output  1  sticky: line_start arrived before NUM_PIXELS samples were taken.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pixel counter and trackers 0. Reset mid-line discards the partial line with no result.
- FSM states:
  - IDLE: ignores sample_valid and waits for line_start.
  - ACQ: accumulates samples.
  - IDLE -> ACQ on line_start.
  - ACQ -> IDLE after the NUM_PIXELS-th accepted sample.
- line_start in ACQ: sets short_line, clears the trackers and counter, stays in ACQ. No result is produced for the aborted line.
- line_start and sample_valid in the same cycle: the sample is pixel 0 of the new line, in either state.
- Per accepted sample, with pixel index = counter value:
  - sum += sample.
  - If index == 0 or sample > current peak (strictly greater), load peak value and index. Ties keep the lowest index.
- Line completion (last sample accepted, cycle N):
  - Final peak/sum, including that last sample, load into the output registers at the clock edge ending cycle N.
  - result_valid is high from cycle N+1, so latency is 1 cycle from the last sample.
  - line_count increments on the same edge.
- Handshake: result_valid && result_ready consumes the result; result_valid falls next cycle unless a new completion occurs that same cycle. Outputs remain stable while result_valid && !result_ready.
- Completion while result_valid is high and result_ready is low: new result overwrites, overrun set, result_valid stays high.
- Completion in the same cycle as a handshake: new result loads, result_valid stays high, no overrun.
- clear_flags clears both sticky flags. A set event in the same cycle as clear_flags wins (flag = 1).
- Sample width: the sum uses zero-extended unsigned samples; no saturation is needed.

Decomposition:
- Package line_peak_pkg: NUM_PIXELS, DATA_W, IDX_W, SUM_W defaults, and FSM state encoding (IDLE=1'b0, ACQ=1'b1).
- Sub-module channel_peak_tracker, instantiated twice (channel 1 and channel 2):
  - Inputs: clk_20M, reset, clear (line restart), sample_en, index, sample.
  - Outputs: peak value, peak index, running sum.
  - The top holds the FSM, pixel counter, result registers, handshake and flags.

Test Plan:
- Ramp line: line_start, then data1 = i, data2 = 127 - i for i = 0..127, result_ready = 1 -> result_valid 1 cycle after last sample; peak1 = 127 @ index 127, peak2 = 127 @ index 0, sum1 = sum2 = 8128, line_count = 1.
- Ties and full scale: all samples 0xFFF except index 5 also 0xFFF -> peak 0xFFF @ index 0, sum = 128*4095 = 524160 (no overflow).
- Backpressure: result_ready = 0 across two complete lines (line 1 peak 100 @ 10, line 2 peak 200 @ 20) -> outputs show line 2, overrun = 1, result_valid = 1; after clear_flags, overrun = 0.
- Short line: line_start, 50 samples, line_start, 128 samples of value 3 -> short_line = 1, single result with sum = 384, line_count = 1.
- Simultaneous events:
  - line_start with sample_valid (value 0x800 at pixel 0) -> pixel 0 counted, peak includes 0x800.
  - Handshake in the completion cycle -> result_valid stays high, overrun = 0.
- Async reset asserted mid-line at pixel 60 -> all outputs 0 immediately; the next full line yields a correct result with line_count = 1.

Source files
------------

// File: rtl/line_peak_pkg.sv
// Shared sizing and FSM encoding for the line peak extractor.
// Imported by the per-channel tracker and the top level.
package line_peak_pkg;

   localparam int NUM_PIXELS = 128;
   localparam int DATA_W     = 12;
   localparam int IDX_W      = 7;
   localparam int SUM_W      = DATA_W + IDX_W;

   typedef enum logic {
      IDLE = 1'b0,
      ACQ  = 1'b1
   } state_e;

endpackage

// File: rtl/channel_peak_tracker.sv
// Per-channel peak value/index and intensity sum tracker for one line.
// Ports: clk_20M, reset, clear_i, sample_en_i, index_i, sample_i in;
//        peak_value_o, peak_index_o, sum_o out (values including the
//        sample accepted this cycle, so the top can latch them directly).
module channel_peak_tracker
   import line_peak_pkg::*;
(
   input  logic              clk_20M,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              sample_en_i,
   input  logic [IDX_W-1:0]  index_i,
   input  logic [DATA_W-1:0] sample_i,
   output logic [DATA_W-1:0] peak_value_o,
   output logic [IDX_W-1:0]  peak_index_o,
   output logic [SUM_W-1:0]  sum_o
);

   logic [DATA_W-1:0] peak_q, peak_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SUM_W-1:0]  sum_q, sum_d;

   always_comb begin
      peak_d = peak_q;
      idx_d  = idx_q;
      sum_d  = sum_q;
      if (clear_i) begin
         peak_d = '0;
         idx_d  = '0;
         sum_d  = '0;
      end
      if (sample_en_i) begin
         // Pixel 0 restarts the line; strict compare keeps the lowest index on ties.
         sum_d = (index_i == '0) ? SUM_W'(sample_i)
                                 : sum_q + SUM_W'(sample_i);
         if (index_i == '0 || sample_i > peak_q) begin
            peak_d = sample_i;
            idx_d  = index_i;
         end
      end
   end

   always_ff @(posedge clk_20M or posedge reset) begin
      if (reset) begin
         peak_q <= '0;
         idx_q  <= '0;
         sum_q  <= '0;
      end else begin
         peak_q <= peak_d;
         idx_q  <= idx_d;
         sum_q  <= sum_d;
      end
   end

   assign peak_value_o = peak_d;
   assign peak_index_o = idx_d;
   assign sum_o        = sum_d;

endmodule

// File: rtl/line_peak_extractor.sv
// Per-line peak/index/sum extractor for the two ADC pixel channels.
// Inputs: clk_20M, reset, line_start, sample_valid, data1/2, result_ready,
//         clear_flags. Outputs: result_valid, peak/index/sum per channel,
//         line_count, sticky overrun and short_line flags.
module line_peak_extractor
   import line_peak_pkg::*;
(
   input  logic              clk_20M,
   input  logic              reset,
   input  logic              line_start,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              result_ready,
   input  logic              clear_flags,
   output logic              result_valid,
   output logic [DATA_W-1:0] peak1_value,
   output logic [DATA_W-1:0] peak2_value,
   output logic [IDX_W-1:0]  peak1_index,
   output logic [IDX_W-1:0]  peak2_index,
   output logic [SUM_W-1:0]  sum1,
   output logic [SUM_W-1:0]  sum2,
   output logic [15:0]       line_count,
   output logic              overrun,
   output logic              short_line
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [15:0]       lcnt_q, lcnt_d;
   logic              ovr_q, ovr_d;
   logic              short_q, short_d;
   logic [DATA_W-1:0] pk1_q, pk2_q;
   logic [IDX_W-1:0]  ix1_q, ix2_q;
   logic [SUM_W-1:0]  s1_q, s2_q;

   logic              accept;
   logic              done;
   logic [IDX_W-1:0]  index;
   logic [DATA_W-1:0] t1_pk, t2_pk;
   logic [IDX_W-1:0]  t1_ix, t2_ix;
   logic [SUM_W-1:0]  t1_s, t2_s;

   // A sample arriving with line_start is pixel 0 of the new line.
   assign accept = sample_valid && (state_q == ACQ || line_start);
   assign index  = line_start ? '0 : cnt_q;
   assign done   = accept && index == IDX_W'(NUM_PIXELS - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      lcnt_d  = lcnt_q;
      ovr_d   = clear_flags ? 1'b0 : ovr_q;
      short_d = clear_flags ? 1'b0 : short_q;
      if (line_start) begin
         state_d = ACQ;
         cnt_d   = accept ? IDX_W'(1) : '0;
         if (state_q == ACQ)
            short_d = 1'b1;
      end else if (accept) begin
         cnt_d = cnt_q + IDX_W'(1);
         if (done)
            state_d = IDLE;
      end
      if (done) begin
         valid_d = 1'b1;
         lcnt_d  = lcnt_q + 16'd1;
         if (valid_q && !result_ready)
            ovr_d = 1'b1;
      end else if (valid_q && result_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_20M or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         lcnt_q  <= '0;
         ovr_q   <= 1'b0;
         short_q <= 1'b0;
         pk1_q   <= '0;
         pk2_q   <= '0;
         ix1_q   <= '0;
         ix2_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         lcnt_q  <= lcnt_d;
         ovr_q   <= ovr_d;
         short_q <= short_d;
         if (done) begin
            pk1_q <= t1_pk;
            pk2_q <= t2_pk;
            ix1_q <= t1_ix;
            ix2_q <= t2_ix;
            s1_q  <= t1_s;
            s2_q  <= t2_s;
         end
      end
   end

   channel_peak_tracker u_ch1 (
      .clk_20M      (clk_20M),
      .reset        (reset),
      .clear_i      (line_start),
      .sample_en_i  (accept),
      .index_i      (index),
      .sample_i     (data1),
      .peak_value_o (t1_pk),
      .peak_index_o (t1_ix),
      .sum_o        (t1_s)
   );

   channel_peak_tracker u_ch2 (
      .clk_20M      (clk_20M),
      .reset        (reset),
      .clear_i      (line_start),
      .sample_en_i  (accept),
      .index_i      (index),
      .sample_i     (data2),
      .peak_value_o (t2_pk),
      .peak_index_o (t2_ix),
      .sum_o        (t2_s)
   );

   assign result_valid = valid_q;
   assign peak1_value  = pk1_q;
   assign peak2_value  = pk2_q;
   assign peak1_index  = ix1_q;
   assign peak2_index  = ix2_q;
   assign sum1         = s1_q;
   assign sum2         = s2_q;
   assign line_count   = lcnt_q;
   assign overrun      = ovr_q;
   assign short_line   = short_q;

endmodule

// File: tb/tb_line_peak_extractor.sv
// Directed bench for line_peak_extractor.
// Hand-computed expectations for ramp, ties, backpressure, short line and reset.
module tb_line_peak_extractor;
   import line_peak_pkg::*;

   logic              clk_20M = 1'b0;
   logic              reset = 1'b1;
   logic              line_start = 1'b0;
   logic              sample_valid = 1'b0;
   logic [DATA_W-1:0] data1 = '0;
   logic [DATA_W-1:0] data2 = '0;
   logic              result_ready = 1'b0;
   logic              clear_flags = 1'b0;
   logic              result_valid;
   logic [DATA_W-1:0] peak1_value, peak2_value;
   logic [IDX_W-1:0]  peak1_index, peak2_index;
   logic [SUM_W-1:0]  sum1, sum2;
   logic [15:0]       line_count;
   logic              overrun, short_line;

   int tests = 0;
   int fails = 0;

   always #25 clk_20M = ~clk_20M;

   line_peak_extractor dut (
      .clk_20M      (clk_20M),
      .reset        (reset),
      .line_start   (line_start),
      .sample_valid (sample_valid),
      .data1        (data1),
      .data2        (data2),
      .result_ready (result_ready),
      .clear_flags  (clear_flags),
      .result_valid (result_valid),
      .peak1_value  (peak1_value),
      .peak2_value  (peak2_value),
      .peak1_index  (peak1_index),
      .peak2_index  (peak2_index),
      .sum1         (sum1),
      .sum2         (sum2),
      .line_count   (line_count),
      .overrun      (overrun),
      .short_line   (short_line)
   );

   task automatic step();
      @(posedge clk_20M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pix(input int mode, input int i,
                                             input bit ch2);
      case (mode)
         0: return ch2 ? DATA_W'(127 - i) : DATA_W'(i);
         1: return 12'hFFF;
         2: return ch2 ? 12'd7 : ((i == 10) ? 12'd100 : 12'd5);
         3: return ch2 ? 12'd7 : ((i == 20) ? 12'd200 : 12'd5);
         4: return 12'd9;
         5: return 12'd3;
         6: return ch2 ? ((i == 0) ? 12'd1 : 12'd2)
                       : ((i == 0) ? 12'h800 : 12'd1);
         default: return '0;
      endcase
   endfunction

   // Feed pixels first..last; with_start raises line_start with pixel first.
   task automatic send(input int mode, input int first, input int last,
                       input bit with_start);
      for (int i = first; i <= last; i++) begin
         line_start   = with_start && (i == first);
         sample_valid = 1'b1;
         data1        = pix(mode, i, 1'b0);
         data2        = pix(mode, i, 1'b1);
         step();
      end
      line_start   = 1'b0;
      sample_valid = 1'b0;
   endtask

   task automatic pulse_start();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_count", 32'(line_count), 0);
      chk("rst_sum1", 32'(sum1), 0);
      chk("rst_peak2", 32'(peak2_value), 0);
      chk("rst_flags", {30'd0, overrun, short_line}, 0);
      reset = 1'b0;
      step();

      // Ramp line
      result_ready = 1'b1;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      chk("idle_ignores", 32'(result_valid), 0);
      pulse_start();
      send(0, 0, 126, 1'b0);
      chk("ramp_not_yet", 32'(result_valid), 0);
      send(0, 127, 127, 1'b0);
      chk("ramp_valid", 32'(result_valid), 1);
      chk("ramp_pk1", 32'(peak1_value), 127);
      chk("ramp_ix1", 32'(peak1_index), 127);
      chk("ramp_pk2", 32'(peak2_value), 127);
      chk("ramp_ix2", 32'(peak2_index), 0);
      chk("ramp_s1", 32'(sum1), 8128);
      chk("ramp_s2", 32'(sum2), 8128);
      chk("ramp_cnt", 32'(line_count), 1);
      step();
      chk("ramp_consumed", 32'(result_valid), 0);

      // Ties at full scale
      pulse_start();
      send(1, 0, 127, 1'b0);
      chk("fs_pk1", 32'(peak1_value), 4095);
      chk("fs_ix1", 32'(peak1_index), 0);
      chk("fs_s1", 32'(sum1), 524160);
      chk("fs_s2", 32'(sum2), 524160);
      chk("fs_cnt", 32'(line_count), 2);
      step();

      // Backpressure over two lines
      result_ready = 1'b0;
      pulse_start();
      send(2, 0, 127, 1'b0);
      chk("bp1_pk1", 32'(peak1_value), 100);
      chk("bp1_ix1", 32'(peak1_index), 10);
      chk("bp1_ovr", 32'(overrun), 0);
      pulse_start();
      send(3, 0, 127, 1'b0);
      step();
      chk("bp2_valid", 32'(result_valid), 1);
      chk("bp2_pk1", 32'(peak1_value), 200);
      chk("bp2_ix1", 32'(peak1_index), 20);
      chk("bp2_s1", 32'(sum1), 835);
      chk("bp2_pk2", 32'(peak2_value), 7);
      chk("bp2_s2", 32'(sum2), 896);
      chk("bp2_ovr", 32'(overrun), 1);
      chk("bp2_cnt", 32'(line_count), 4);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("bp_clr_ovr", 32'(overrun), 0);
      chk("bp_clr_hold", 32'(result_valid), 1);
      result_ready = 1'b1;
      step();
      chk("bp_consumed", 32'(result_valid), 0);

      // Short line, result left pending for the next test
      pulse_start();
      send(4, 0, 49, 1'b0);
      pulse_start();
      chk("sh_flag", 32'(short_line), 1);
      chk("sh_nores", 32'(line_count), 4);
      result_ready = 1'b0;
      send(5, 0, 127, 1'b0);
      chk("sh_s1", 32'(sum1), 384);
      chk("sh_pk1", 32'(peak1_value), 3);
      chk("sh_cnt", 32'(line_count), 5);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("sh_clr", 32'(short_line), 0);

      // line_start with pixel 0, handshake in completion cycle
      send(6, 0, 126, 1'b1);
      result_ready = 1'b1;
      send(6, 127, 127, 1'b0);
      chk("sim_valid", 32'(result_valid), 1);
      chk("sim_ovr", 32'(overrun), 0);
      chk("sim_short", 32'(short_line), 0);
      chk("sim_pk1", 32'(peak1_value), 12'h800);
      chk("sim_ix1", 32'(peak1_index), 0);
      chk("sim_s1", 32'(sum1), 2175);
      chk("sim_pk2", 32'(peak2_value), 2);
      chk("sim_ix2", 32'(peak2_index), 1);
      chk("sim_s2", 32'(sum2), 255);
      chk("sim_cnt", 32'(line_count), 6);
      step();
      chk("sim_consumed", 32'(result_valid), 0);

      // Async reset mid-line
      pulse_start();
      send(0, 0, 59, 1'b0);
      #10;
      reset = 1'b1;
      #1;
      chk("ar_cnt", 32'(line_count), 0);
      chk("ar_s1", 32'(sum1), 0);
      chk("ar_pk1", 32'(peak1_value), 0);
      step();
      reset = 1'b0;
      step();
      pulse_start();
      send(0, 0, 127, 1'b0);
      chk("ar_valid", 32'(result_valid), 1);
      chk("ar_line_cnt", 32'(line_count), 1);
      chk("ar_line_s1", 32'(sum1), 8128);
      chk("ar_line_ix1", 32'(peak1_index), 127);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
